axi4_lite_slave_regfile: RTL and testbench

- Parametrised AXI4-Lite slave that terminates all five channels into an internal register file of NUM_REGS x DATA_WIDTH registers.
- Adds behaviour the first-generation slave adaptor lacks:
  - independent AW/W acceptance with buffering;
  - byte-strobed writes into addressed registers;
  - SLVERR on out-of-range addresses;
  - fully held VALID until READY.
- Sits between the interconnect and peripheral logic; register contents are exported flat, with per-register write pulses.

---
 rtl/axi4_lite_slave_regfile.sv | 217 +++++++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave that terminates all five channels into a NUM_REGS x DATA_WIDTH
// register file.
//   AW/W  : independent one-deep buffers, commit once both are full
//   B     : response held until bready_in, SLVERR for out-of-range addresses
//   AR/R  : one read in flight, data captured on the AR handshake edge
//   regs_out     : flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_out : one-cycle pulse on bit i when register i is written
module axi4_lite_slave_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr_in,
    input  logic [2:0]                     awprot_in,
    input  logic                           awvalid_in,
    output logic                           awready_out,
    input  logic [DATA_WIDTH-1:0]          wdata_in,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_in,
    input  logic                           wvalid_in,
    output logic                           wready_out,
    output logic [1:0]                     bresp_out,
    output logic                           bvalid_out,
    input  logic                           bready_in,
    input  logic [ADDR_WIDTH-1:0]          araddr_in,
    input  logic [2:0]                     arprot_in,
    input  logic                           arvalid_in,
    output logic                           arready_out,
    output logic [DATA_WIDTH-1:0]          rdata_out,
    output logic [1:0]                     rresp_out,
    output logic                           rvalid_out,
    input  logic                           rready_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse_out
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned OFS_W  = $clog2(STRB_W);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_ACCEPT, W_RESP } wstate_e;
    typedef enum logic { R_ADDR,   R_DATA } rstate_e;

    // Protection bits carry no meaning for this register file.
    logic unused_c;
    assign unused_c = ^{awprot_in, arprot_in};

    // Address is in range when the index is below NUM_REGS and no higher bit is set.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [IDX_W-1:0] idx;
        idx = a[OFS_W +: IDX_W];
        return (32'(idx) < NUM_REGS) && ((a >> (OFS_W + IDX_W)) == '0);
    endfunction

    wstate_e                              wstate_q, wstate_d;
    rstate_e                              rstate_q, rstate_d;
    logic                                 aw_full_q, aw_full_d;
    logic                                 w_full_q, w_full_d;
    logic [ADDR_WIDTH-1:0]                aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0]                w_data_q, w_data_d;
    logic [STRB_W-1:0]                    w_strb_q, w_strb_d;
    logic                                 awready_q, awready_d;
    logic                                 wready_q, wready_d;
    logic                                 bvalid_q, bvalid_d;
    logic [1:0]                           bresp_q, bresp_d;
    logic                                 arready_q, arready_d;
    logic                                 rvalid_q, rvalid_d;
    logic [1:0]                           rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]                     aw_idx_c, ar_idx_c;

    assign aw_idx_c = aw_addr_q[OFS_W +: IDX_W];
    assign ar_idx_c = araddr_in[OFS_W +: IDX_W];

    // Write path: buffer AW and W independently, commit when both are held.
    always_comb begin
        wstate_d   = wstate_q;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        unique case (wstate_q)
            W_ACCEPT: begin
                if (aw_full_q && w_full_q) begin
                    if (addr_ok(aw_addr_q)) begin
                        for (int k = 0; k < int'(STRB_W); k++) begin
                            if (w_strb_q[k]) begin
                                regs_d[aw_idx_c][k*8 +: 8] = w_data_q[k*8 +: 8];
                            end
                        end
                        wr_pulse_d[aw_idx_c] = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                end else begin
                    if (awvalid_in && awready_q) begin
                        aw_addr_d = awaddr_in;
                        aw_full_d = 1'b1;
                    end
                    if (wvalid_in && wready_q) begin
                        w_data_d = wdata_in;
                        w_strb_d = wstrb_in;
                        w_full_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bready_in) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_ACCEPT;
                end
            end
            default: wstate_d = W_ACCEPT;
        endcase
        // Ready flags are registered images of the next-cycle acceptance condition.
        awready_d = (wstate_d == W_ACCEPT) && !aw_full_d;
        wready_d  = (wstate_d == W_ACCEPT) && !w_full_d;
    end

    // Read path: capture data on the AR handshake, hold until R handshake.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (rstate_q)
            R_ADDR: begin
                if (arvalid_in && arready_q) begin
                    if (addr_ok(araddr_in)) begin
                        rdata_d = regs_q[ar_idx_c];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rready_in) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_ADDR;
                end
            end
            default: rstate_d = R_ADDR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q   <= W_ACCEPT;
            rstate_q   <= R_ADDR;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign awready_out  = awready_q;
    assign wready_out   = wready_q;
    assign bvalid_out   = bvalid_q;
    assign bresp_out    = bresp_q;
    assign arready_out  = arready_q;
    assign rvalid_out   = rvalid_q;
    assign rresp_out    = rresp_q;
    assign rdata_out    = rdata_q;
    assign regs_out     = regs_q;
    assign wr_pulse_out = wr_pulse_q;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomized bench for axi4_lite_slave_regfile (32-bit data, 16 registers) checked
// against an array model of the register file.
module tb_axi4_lite_slave_regfile;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NR = 16;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     awaddr_in, araddr_in;
    logic [2:0]        awprot_in, arprot_in;
    logic              awvalid_in, awready_out;
    logic [DW-1:0]     wdata_in;
    logic [DW/8-1:0]   wstrb_in;
    logic              wvalid_in, wready_out;
    logic [1:0]        bresp_out, rresp_out;
    logic              bvalid_out, bready_in;
    logic              arvalid_in, arready_out;
    logic [DW-1:0]     rdata_out;
    logic              rvalid_out, rready_in;
    logic [NR*DW-1:0]  regs_out;
    logic [NR-1:0]     wr_pulse_out;

    always #5 clk = ~clk;

    axi4_lite_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .aclk(clk), .aresetn(aresetn),
        .awaddr_in(awaddr_in), .awprot_in(awprot_in), .awvalid_in(awvalid_in),
        .awready_out(awready_out),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in),
        .wready_out(wready_out),
        .bresp_out(bresp_out), .bvalid_out(bvalid_out), .bready_in(bready_in),
        .araddr_in(araddr_in), .arprot_in(arprot_in), .arvalid_in(arvalid_in),
        .arready_out(arready_out),
        .rdata_out(rdata_out), .rresp_out(rresp_out), .rvalid_out(rvalid_out),
        .rready_in(rready_in),
        .regs_out(regs_out), .wr_pulse_out(wr_pulse_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] m_regs [NR];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Word-granular view: a byte address maps to register addr/4 when that is below NR.
    function automatic bit in_range(input logic [AW-1:0] a);
        return (a >> 2) < NR;
    endfunction

    function automatic int reg_of(input logic [AW-1:0] a);
        return int'(a >> 2);
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f = '0;
        for (int i = 0; i < int'(NR); i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) m_regs[reg_of(a)][k*8 +: 8] = d[k*8 +: 8];
        end
    endtask

    function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] a);
        logic [NR-1:0] p = '0;
        if (in_range(a)) p[reg_of(a)] = 1'b1;
        return p;
    endfunction

    task automatic drive_aw(input logic [AW-1:0] a, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        awaddr_in = a; awprot_in = 3'($urandom); awvalid_in = 1'b1;
        while (!awready_out && n < 40) begin @(negedge clk); n++; end
        check("aw_accept", 512'(awready_out), 512'(1));
        @(negedge clk);
        awvalid_in = 1'b0;
        check("awready_low_after_aw", 512'(awready_out), 512'(0));
    endtask

    task automatic drive_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        wdata_in = d; wstrb_in = s; wvalid_in = 1'b1;
        while (!wready_out && n < 40) begin @(negedge clk); n++; end
        check("w_accept", 512'(wready_out), 512'(1));
        @(negedge clk);
        wvalid_in = 1'b0;
        check("wready_low_after_w", 512'(wready_out), 512'(0));
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!bvalid_out && n < 20) begin @(negedge clk); n++; end
        check("bvalid_rise", 512'(bvalid_out), 512'(1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] er;
        er = in_range(a) ? 2'b00 : 2'b10;
        fork
            drive_aw(a, aw_dly);
            drive_w(d, s, w_dly);
        join
        wait_bvalid();
        model_write(a, d, s);
        check("bresp", 512'(bresp_out), 512'(er));
        check("wr_pulse", 512'(wr_pulse_out), 512'(exp_pulse(a)));
        check("regs_after_write", 512'(regs_out), model_flat());
        repeat (b_dly) begin
            @(negedge clk);
            check("bvalid_hold", 512'(bvalid_out), 512'(1));
            check("bresp_hold", 512'(bresp_out), 512'(er));
            check("ready_low_in_resp", 512'({awready_out, wready_out}), 512'(0));
        end
        bready_in = 1'b1;
        @(negedge clk);
        bready_in = 1'b0;
        check("bvalid_drop", 512'(bvalid_out), 512'(0));
        check("wr_pulse_clear", 512'(wr_pulse_out), 512'(0));
        check("ready_after_b", 512'({awready_out, wready_out}), 512'(3));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int r_dly);
        int n = 0;
        logic [DW-1:0] ed;
        logic [1:0]    er;
        ed = in_range(a) ? m_regs[reg_of(a)] : '0;
        er = in_range(a) ? 2'b00 : 2'b10;
        araddr_in = a; arprot_in = 3'($urandom); arvalid_in = 1'b1;
        while (!arready_out && n < 40) begin @(negedge clk); n++; end
        check("ar_accept", 512'(arready_out), 512'(1));
        @(negedge clk);
        arvalid_in = 1'b0;
        check("rvalid_latency", 512'(rvalid_out), 512'(1));
        check("rdata", 512'(rdata_out), 512'(ed));
        check("rresp", 512'(rresp_out), 512'(er));
        check("arready_low", 512'(arready_out), 512'(0));
        repeat (r_dly) begin
            @(negedge clk);
            check("rvalid_hold", 512'(rvalid_out), 512'(1));
            check("rdata_hold", 512'(rdata_out), 512'(ed));
            check("arready_low_hold", 512'(arready_out), 512'(0));
        end
        rready_in = 1'b1;
        @(negedge clk);
        rready_in = 1'b0;
        check("rvalid_drop", 512'(rvalid_out), 512'(0));
        check("arready_back", 512'(arready_out), 512'(1));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sel = $urandom_range(0, 9);
        logic [AW-1:0] a;
        if (sel < 7)       a = AW'($urandom_range(0, NR - 1) * 4 + $urandom_range(0, 3));
        else if (sel == 7) a = AW'(32'h40 + $urandom_range(0, 15) * 4);
        else if (sel == 8) a = AW'(32'h1000 << $urandom_range(0, 8));
        else               a = AW'($urandom);
        return a;
    endfunction

    initial begin
        logic [DW-1:0] old2;
        aresetn = 1'b0;
        awaddr_in = '0; awprot_in = '0; awvalid_in = 1'b0;
        wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0; bready_in = 1'b0;
        araddr_in = '0; arprot_in = '0; arvalid_in = 1'b0; rready_in = 1'b0;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_readies", 512'({awready_out, wready_out, arready_out}), 512'(7));
        check("rst_valids", 512'({bvalid_out, rvalid_out}), 512'(0));
        check("rst_resps", 512'({bresp_out, rresp_out}), 512'(0));
        check("rst_rdata", 512'(rdata_out), 512'(0));
        check("rst_regs", 512'(regs_out), 512'(0));
        check("rst_pulse", 512'(wr_pulse_out), 512'(0));
        aresetn = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(32'h08, 32'h000000AA, 4'b0001, 2, 0, 0);
        check("strobed_byte_reg2", 512'(regs_out[2*32 +: 32]), 512'(32'hDEADBEAA));
        do_write(32'h40, 32'h55555555, 4'hF, 0, 0, 0);
        do_write(32'h3C, 32'h12345678, 4'hF, 0, 1, 0);
        do_read(32'h3C, 0);
        do_read(32'h1000, 0);
        do_write(32'h04, 32'hCAFEF00D, 4'hF, 0, 0, 5);
        do_write(32'h14, 32'h0BADBEEF, 4'h0, 0, 0, 0);
        do_read(32'h08, 4);

        // AR handshake on the same edge as the write commit to reg2.
        old2 = m_regs[2];
        awaddr_in = 32'h08; awvalid_in = 1'b1;
        wdata_in = 32'h11111111; wstrb_in = 4'hF; wvalid_in = 1'b1;
        @(negedge clk);
        awvalid_in = 1'b0; wvalid_in = 1'b0;
        araddr_in = 32'h08; arvalid_in = 1'b1;
        @(negedge clk);
        arvalid_in = 1'b0;
        model_write(32'h08, 32'h11111111, 4'hF);
        check("same_edge_bvalid", 512'(bvalid_out), 512'(1));
        check("same_edge_rvalid", 512'(rvalid_out), 512'(1));
        check("same_edge_old_data", 512'(rdata_out), 512'(old2));
        check("same_edge_regs", 512'(regs_out), model_flat());
        bready_in = 1'b1; rready_in = 1'b1;
        @(negedge clk);
        bready_in = 1'b0; rready_in = 1'b0;
        do_read(32'h08, 0);

        // Random mix of writes and reads.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) < 6)
                do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 3));
        end

        // Asynchronous reset while a write response is pending.
        fork
            drive_aw(32'h0C, 0);
            drive_w(32'h77777777, 4'hF, 1);
        join
        wait_bvalid();
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        check("async_rst_bvalid", 512'(bvalid_out), 512'(0));
        check("async_rst_regs", 512'(regs_out), 512'(0));
        check("async_rst_awready", 512'(awready_out), 512'(1));
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_b_after_rst", 512'(bvalid_out), 512'(0));
            check("awready_after_rst", 512'(awready_out), 512'(1));
        end
        do_read(32'h0C, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
